freq_meter_spi_mc: RTL

FREQ_METER_SPI_MC -- requirements
Module: freq_meter_spi_mc

---
 rtl/freq_meter_spi_mc.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/freq_meter_spi_mc.sv
`timescale 1ns/1ps
// Multi-channel frequency meter: counts rising edges of CH_NUM asynchronous
// inputs over a fixed gate window and ships the counts out on a mode-0 SPI
// link (channel 0 first, MSB first).
// Optional feature: define FREQ_METER_CRC_EN to append a CRC-8 (poly 0x07,
// init 0x00) computed over the data bits in transmit order.
module freq_meter_spi_mc #(
    parameter int unsigned CH_NUM   = 2,
    parameter int unsigned CNT_W    = 24,
    parameter int unsigned GATE_CYC = 100000,
    parameter int unsigned SCK_DIV  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH_NUM-1:0] sig_in,
    input  logic              en,
    output logic              SCK,
    output logic              MOSI,
    output logic              CS,
    output logic              BUSY,
    output logic [1:0]        Status,
    output logic [CH_NUM-1:0] ovf
);

    localparam int unsigned DATA_W = CH_NUM * CNT_W;
`ifdef FREQ_METER_CRC_EN
    localparam int unsigned CRC_W  = 8;
`else
    localparam int unsigned CRC_W  = 0;
`endif
    localparam int unsigned FRAME_W = DATA_W + CRC_W;
    localparam int unsigned GATE_W  = $clog2(GATE_CYC);
    localparam int unsigned DIV_W   = $clog2(SCK_DIV + 1);
    localparam int unsigned BIT_W   = $clog2(FRAME_W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_GATE = 2'b01,
        S_SEND = 2'b10,
        S_LOAD = 2'b11
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_busy;

    logic [CH_NUM-1:0]   r_sync1;
    logic [CH_NUM-1:0]   r_sync2;
    logic [CH_NUM-1:0]   r_sync3;
    logic [CH_NUM-1:0]   w_edge;

    logic [CNT_W-1:0]    r_cnt [CH_NUM];
    logic [CH_NUM-1:0]   r_sticky;
    logic [GATE_W-1:0]   r_gate_cnt;
    logic                w_gate_start;

    logic [DATA_W-1:0]   w_data;
    logic [FRAME_W-1:0]  w_frame;
    logic [FRAME_W-1:0]  r_shift;
    logic [DIV_W-1:0]    r_div;
    logic [BIT_W-1:0]    r_bit;
    logic                r_fin;
    logic                r_sck;
    logic                r_mosi;
    logic                r_cs;
    logic [CH_NUM-1:0]   r_ovf;
    logic                w_send_done;

    // Two-flop synchroniser plus a third stage for rising-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= sig_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_edge       = r_sync2 & ~r_sync3;
    assign w_gate_start = (w_state_nxt == S_GATE) && (r_state != S_GATE);
    assign w_send_done  = (r_state == S_SEND) && r_fin && (r_div == DIV_W'(SCK_DIV - 1));

    // State register; BUSY is registered alongside the state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    // Next-state logic; en is only looked at in IDLE and at frame end
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (en) w_state_nxt = S_GATE;
            S_GATE:  if (r_gate_cnt == GATE_W'(GATE_CYC - 1)) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_SEND;
            S_SEND:  if (w_send_done) w_state_nxt = en ? S_GATE : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Gate timer and saturating edge counters, live only while in GATE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '{default: '0};
            r_sticky   <= '0;
            r_gate_cnt <= '0;
        end else if (w_gate_start) begin
            r_cnt      <= '{default: '0};
            r_sticky   <= '0;
            r_gate_cnt <= '0;
        end else if (r_state == S_GATE) begin
            r_gate_cnt <= r_gate_cnt + GATE_W'(1);
            for (int i = 0; i < int'(CH_NUM); i++) begin
                if (w_edge[i]) begin
                    if (r_cnt[i] == {CNT_W{1'b1}}) r_sticky[i] <= 1'b1;
                    else                           r_cnt[i]    <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Pack counters with channel 0 in the most significant (first sent) bits
    always_comb begin
        w_data = '0;
        for (int i = 0; i < int'(CH_NUM); i++) begin
            w_data = (w_data << CNT_W) | DATA_W'(r_cnt[i]);
        end
    end

`ifdef FREQ_METER_CRC_EN
    // Bit-serial CRC-8 over the data bits, MSB first
    function automatic logic [7:0] crc8(input logic [DATA_W-1:0] d);
        logic [7:0]        c;
        logic [DATA_W-1:0] s;
        logic              fb;
        c = '0;
        s = d;
        for (int i = 0; i < int'(DATA_W); i++) begin
            fb = c[7] ^ s[DATA_W-1];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            s  = s << 1;
        end
        return c;
    endfunction

    assign w_frame = {w_data, crc8(w_data)};
`else
    assign w_frame = w_data;
`endif

    // SPI shifter: LOAD primes CS/MOSI, SEND toggles SCK every SCK_DIV cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift <= '0;
            r_div   <= '0;
            r_bit   <= '0;
            r_fin   <= 1'b0;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
            r_cs    <= 1'b1;
            r_ovf   <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_shift <= w_frame;
                    r_mosi  <= w_frame[FRAME_W-1];
                    r_cs    <= 1'b0;
                    r_sck   <= 1'b0;
                    r_div   <= '0;
                    r_bit   <= '0;
                    r_fin   <= 1'b0;
                    r_ovf   <= r_sticky;
                end
                S_SEND: begin
                    if (r_div == DIV_W'(SCK_DIV - 1)) begin
                        r_div <= '0;
                        if (r_fin) begin
                            r_cs <= 1'b1;
                        end else if (!r_sck) begin
                            r_sck <= 1'b1;
                        end else begin
                            // Falling edge: advance to the next bit
                            r_sck   <= 1'b0;
                            r_shift <= r_shift << 1;
                            r_mosi  <= r_shift[FRAME_W-2];
                            r_bit   <= r_bit + BIT_W'(1);
                            if (r_bit == BIT_W'(FRAME_W - 1)) r_fin <= 1'b1;
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                default: begin
                    r_cs   <= 1'b1;
                    r_sck  <= 1'b0;
                    r_mosi <= 1'b0;
                end
            endcase
        end
    end

    assign SCK    = r_sck;
    assign MOSI   = r_mosi;
    assign CS     = r_cs;
    assign BUSY   = r_busy;
    assign Status = r_state;
    assign ovf    = r_ovf;

endmodule
